// File: rtl/gon_tag_scheduler.sv
// gon_tag_scheduler
//   Drives the tag write side of the GON output path. It walks the active
//   PE sub-array (cfg_num_rows x cfg_num_cols) in row-major order for
//   cfg_num_passes sweeps. Each {row, col} tag is pushed into the tags FIFO,
//   and the FIFO full flag stalls the walk. The block then counts the data
//   words the consumer drains and pulses done once every issued tag has
//   produced a word.
//
// Ports
//   clk, reset            : clock, async active-high reset
//   start, abort          : job start (IDLE only), synchronous abort (any state)
//   cfg_num_rows/cols/
//   cfg_num_passes        : job geometry, latched on an accepted start
//   tags_full             : tags FIFO full (backpressure)
//   tags_wr_en            : tag write strobe (combinational)
//   row_tag, col_tag      : current tag (registered counters)
//   data_rd_en, data_empty: consumer read strobe / data FIFO empty (observed)
//   busy                  : high in ISSUE and DRAIN
//   done                  : one-cycle completion pulse
//   cfg_error             : one-cycle pulse on an illegal config
module gon_tag_scheduler #(
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_ROWS   = 12,
   parameter int NUM_OF_COLS   = 14,
   parameter int PASS_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ROW_TAG_WIDTH-1:0] cfg_num_rows,
   input  logic [COL_TAG_WIDTH-1:0] cfg_num_cols,
   input  logic [PASS_WIDTH-1:0]    cfg_num_passes,
   input  logic                     tags_full,
   output logic                     tags_wr_en,
   output logic [ROW_TAG_WIDTH-1:0] row_tag,
   output logic [COL_TAG_WIDTH-1:0] col_tag,
   input  logic                     data_rd_en,
   input  logic                     data_empty,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_error
);

   localparam int RW = ROW_TAG_WIDTH;
   localparam int CLW = COL_TAG_WIDTH;
   localparam int PW = PASS_WIDTH;
   // Word counters hold rows*cols*passes without overflow.
   localparam int CW = PW + RW + CLW;
   localparam logic [RW-1:0]  MAX_ROWS = RW'(NUM_OF_ROWS);
   localparam logic [CLW-1:0] MAX_COLS = CLW'(NUM_OF_COLS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   rows_q, rows_d, row_q, row_d;
   logic [CLW-1:0]  cols_q, cols_d, col_q, col_d;
   logic [PW-1:0]   passes_q, passes_d, pass_q, pass_d;
   logic [CW-1:0]   total_q, total_d;
   logic [CW-1:0]   issued_q, issued_d;
   logic [CW-1:0]   rcvd_q, rcvd_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cfg_error_q, cfg_error_d;

   logic            cfg_bad;
   logic            rd_hit;

   assign tags_wr_en = (state_q == ISSUE) & ~tags_full;
   assign row_tag    = row_q;
   assign col_tag    = col_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_error  = cfg_error_q;

   assign cfg_bad = (cfg_num_rows == '0) || (cfg_num_cols == '0) ||
                    (cfg_num_passes == '0) ||
                    (cfg_num_rows > MAX_ROWS) || (cfg_num_cols > MAX_COLS);

   // A read only counts while data is present; holding at total makes an
   // over-reading consumer saturate instead of wrapping.
   assign rd_hit = data_rd_en & ~data_empty & (rcvd_q != total_q);

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      passes_d    = passes_q;
      total_d     = total_q;
      row_d       = row_q;
      col_d       = col_q;
      pass_d      = pass_q;
      issued_d    = issued_q;
      rcvd_d      = rcvd_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cfg_error_d = 1'b0;

      if (abort) begin
         state_d  = IDLE;
         row_d    = '0;
         col_d    = '0;
         pass_d   = '0;
         issued_d = '0;
         rcvd_d   = '0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  rows_d   = cfg_num_rows;
                  cols_d   = cfg_num_cols;
                  passes_d = cfg_num_passes;
                  total_d  = CW'(cfg_num_rows) * CW'(cfg_num_cols) *
                             CW'(cfg_num_passes);
                  row_d    = '0;
                  col_d    = '0;
                  pass_d   = '0;
                  issued_d = '0;
                  rcvd_d   = '0;
                  if (cfg_bad) begin
                     cfg_error_d = 1'b1;
                  end else begin
                     state_d = ISSUE;
                     busy_d  = 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (rd_hit) rcvd_d = rcvd_q + CW'(1);
               if (tags_wr_en) begin
                  issued_d = issued_q + CW'(1);
                  if (col_q == cols_q - CLW'(1)) begin
                     col_d = '0;
                     if (row_q == rows_q - RW'(1)) begin
                        row_d  = '0;
                        pass_d = pass_q + PW'(1);
                        if (pass_q == passes_q - PW'(1)) state_d = DRAIN;
                     end else begin
                        row_d = row_q + RW'(1);
                     end
                  end else begin
                     col_d = col_q + CLW'(1);
                  end
               end
            end
            DRAIN: begin
               if (rd_hit) rcvd_d = rcvd_q + CW'(1);
               // issued equals total once the walk has finished
               if (rcvd_q == issued_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         passes_q    <= '0;
         total_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         pass_q      <= '0;
         issued_q    <= '0;
         rcvd_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         passes_q    <= passes_d;
         total_q     <= total_d;
         row_q       <= row_d;
         col_q       <= col_d;
         pass_q      <= pass_d;
         issued_q    <= issued_d;
         rcvd_q      <= rcvd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_error_q <= cfg_error_d;
      end
   end

endmodule

// File: tb/tb_gon_tag_scheduler.sv
// Bench for gon_tag_scheduler. The expected tag stream is a queue built
// from nested pass/row/col loops. The consumer is modelled as a word count
// in the data FIFO. The done cycle is derived from the cycle of the last
// write and the cycle of the last counted read.
module tb_gon_tag_scheduler;

   localparam int BOUND = 8000;

   logic        clk = 1'b0;
   logic        reset, start, abort, tags_full, data_rd_en, data_empty;
   logic [3:0]  cfg_num_rows, cfg_num_cols;
   logic [15:0] cfg_num_passes;
   logic        tags_wr_en, busy, done, cfg_error;
   logic [3:0]  row_tag, col_tag;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   gon_tag_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols),
      .cfg_num_passes(cfg_num_passes), .tags_full(tags_full),
      .tags_wr_en(tags_wr_en), .row_tag(row_tag), .col_tag(col_tag),
      .data_rd_en(data_rd_en), .data_empty(data_empty),
      .busy(busy), .done(done), .cfg_error(cfg_error)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One job: start at relative cycle 0, then run until done (+1 cycle),
   // abort (+1 cycle), or a few cycles after an illegal config.
   task automatic run_job(input int rows, input int cols, input int passes,
                          input int bp_pct, input int rd_pct,
                          input int full_lo, input int full_hi,
                          input int abort_at, input int glitch_at,
                          output int first_wr, output int last_wr, output int nwr);
      int  q_r[$], q_c[$];
      int  total, avail, reads, rlast, done_seen, exp_done;
      bit  illegal, fin, wr;
      first_wr = 0; last_wr = 0; nwr = 0;
      avail = 0; reads = 0; rlast = 0; done_seen = 0; fin = 0;
      illegal = (rows == 0) || (cols == 0) || (passes == 0) || (rows > 12) || (cols > 14);
      total = illegal ? 0 : rows * cols * passes;
      if (!illegal)
         for (int p = 0; p < passes; p++)
            for (int r = 0; r < rows; r++)
               for (int c = 0; c < cols; c++) begin
                  q_r.push_back(r);
                  q_c.push_back(c);
               end

      cfg_num_rows   = rows[3:0];
      cfg_num_cols   = cols[3:0];
      cfg_num_passes = passes[15:0];
      start = 1'b1; abort = 1'b0; tags_full = 1'b0;
      data_rd_en = 1'b0; data_empty = 1'b1;
      @(posedge clk); #1;

      for (int rel = 1; rel <= BOUND && !fin; rel++) begin
         start      = (rel == glitch_at);
         abort      = (rel == abort_at);
         tags_full  = (rel >= full_lo && rel <= full_hi) || ($urandom_range(99) < bp_pct);
         data_empty = (avail == 0);
         data_rd_en = (reads < total) && ($urandom_range(99) < rd_pct);
         #1;
         if (rel == 1) chk("cfg_error_pulse", cfg_error, illegal);
         if (rel == 2) chk("cfg_error_width", cfg_error, 0);
         if (illegal) begin
            chk("bad_cfg_wr", tags_wr_en, 0);
            chk("bad_cfg_busy", busy, 0);
            chk("bad_cfg_done", done, 0);
            if (rel == 4) fin = 1;
         end else if (abort_at != 0 && rel == abort_at + 1) begin
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_row", row_tag, 0);
            chk("abort_col", col_tag, 0);
            chk("abort_wr", tags_wr_en, 0);
            fin = 1;
         end else begin
            wr = tags_wr_en;
            if (tags_full) chk("wr_while_full", tags_wr_en, 0);
            if (wr) begin
               if (nwr < total) begin
                  chk("row_tag", row_tag, q_r[nwr]);
                  chk("col_tag", col_tag, q_c[nwr]);
               end else begin
                  chk("write_count", nwr + 1, total);
               end
               if (nwr == 0) first_wr = rel;
               nwr++;
               if (nwr == total) last_wr = rel;
            end
            if (done_seen != 0) begin
               chk("done_width", done, 0);
               chk("busy_after_done", busy, 0);
               fin = 1;
            end else if (done) begin
               exp_done = ((last_wr > rlast) ? last_wr : rlast) + 2;
               chk("done_cycle", rel, exp_done);
               chk("done_reads", reads, total);
               chk("done_writes", nwr, total);
               chk("busy_in_done", busy, 0);
               done_seen = rel;
            end else begin
               chk("busy_active", busy, 1);
            end
            if (data_rd_en && !data_empty) begin
               avail--;
               reads++;
               if (reads == total) rlast = rel;
            end
            if (wr) avail++;
         end
         @(posedge clk); #1;
      end
      if (!fin) chk("job_timeout", 0, 1);
      start = 1'b0; abort = 1'b0; tags_full = 1'b0;
      data_rd_en = 1'b0; data_empty = 1'b1;
   endtask

   typedef struct {
      int rows, cols, passes, full_lo, full_hi, exp_first, exp_last;
   } vec_t;

   initial begin
      vec_t tbl[11];
      int f, l, n;
      int r, c, p, tot;
      tbl = '{
         '{2,  3,  1, 0, 0, 1, 6},
         '{2,  3,  1, 2, 4, 1, 9},
         '{1,  1,  1, 0, 0, 1, 1},
         '{12, 14, 2, 0, 0, 1, 336},
         '{1,  14, 3, 0, 0, 1, 42},
         '{12, 1,  1, 0, 0, 1, 12},
         '{3,  0,  1, 0, 0, 0, 0},
         '{13, 2,  1, 0, 0, 0, 0},
         '{2,  15, 1, 0, 0, 0, 0},
         '{0,  3,  1, 0, 0, 0, 0},
         '{2,  3,  0, 0, 0, 0, 0}
      };

      reset = 1'b1; start = 1'b0; abort = 1'b0; tags_full = 1'b0;
      data_rd_en = 1'b0; data_empty = 1'b1;
      cfg_num_rows = '0; cfg_num_cols = '0; cfg_num_passes = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr", tags_wr_en, 0);
      chk("rst_row", row_tag, 0);
      chk("rst_col", col_tag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_error", cfg_error, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Table: fixed geometries, always-ready consumer.
      foreach (tbl[i]) begin
         run_job(tbl[i].rows, tbl[i].cols, tbl[i].passes, 0, 100,
                 tbl[i].full_lo, tbl[i].full_hi, 0, 0, f, l, n);
         chk("tbl_first_wr", f, tbl[i].exp_first);
         chk("tbl_last_wr", l, tbl[i].exp_last);
      end

      // Abort partway through a large job, with a start glitch in ISSUE,
      // then a fresh job must restart from (0,0).
      run_job(12, 14, 2, 20, 70, 0, 0, 100, 3, f, l, n);
      chk("abort_partial", (n > 0 && n < 336), 1);
      run_job(2, 3, 1, 0, 100, 0, 0, 0, 0, f, l, n);
      chk("restart_first", f, 1);
      chk("restart_last", l, 6);

      // Random geometries, backpressure and consumer rate.
      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(12, 1);
         c = $urandom_range(14, 1);
         p = $urandom_range(3, 1);
         tot = r * c * p;
         run_job(r, c, p, $urandom_range(60, 0), $urandom_range(100, 30),
                 0, 0, 0, (tot >= 4) ? 3 : 0, f, l, n);
         chk("rand_writes", n, tot);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
